// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
// line levels and the parity helper.
package uart_pkg;

    // Transmitter FSM states. The encoding is fixed so that the debug state
    // output stays stable across revisions.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_FETCH  = 3'd1,
        TX_LOAD   = 3'd2,
        TX_START  = 3'd3,
        TX_DATA   = 3'd4,
        TX_PARITY = 3'd5,
        TX_STOP   = 3'd6
    } tx_state_t;

    // Serial line levels.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Widest word the parity helper accepts. Callers zero-extend their data,
    // and the extra zeros do not change the XOR.
    localparam int PARITY_MAX_W = 64;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                         input logic                    odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by a consumer.
//
// Handshake: the consumer raises fifo_rd_en for exactly one cycle, and only
// after it has seen fifo_empty low. The FIFO presents the popped word on
// fifo_rd_data in the cycle after the strobe. The data path has no
// backpressure, and the consumer must not strobe again until it has used
// the word.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;

    // master: the consumer (UART transmitter) side
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    // slave: the FIFO side
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter. It counts 0..CLKS_PER_BIT-1 and wraps. tick marks the
// last cycle of a bit time. tick_next marks the cycle before that, so the
// owner can register outputs that must line up with the final cycle.
// clear restarts the count so that the next cycle is cycle 0 of a new bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on clear or at the bit boundary, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick      = (cnt_q == LAST);
    assign tick_next = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter. It pops one word per frame from the FIFO read
// port and sends start, WIDTH data bits LSB first, an optional parity bit,
// and then STOP_BITS stop bits. While the FIFO has data it drains it back to
// back, and it idles with the line high otherwise. Every output comes from a
// flop. Each flop's next value is derived from the FSM's next state, so the
// outputs change on the same edge as the state.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    fifo_uart_tx_if.master         fifo,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output tx_state_t              dbg_state
);

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_FETCH  = TX_FETCH;
    localparam logic [2:0] ST_LOAD   = TX_LOAD;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
    localparam logic [2:0] ST_PARITY = TX_PARITY;
    localparam logic [2:0] ST_STOP   = TX_STOP;

    // The bit counter indexes data bits in DATA and stop bits in STOP.
    localparam int            BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic [2:0]       state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [BW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic             parity_q,     parity_d;
    logic             tx_q,         tx_d;
    logic             fifo_rd_en_q, fifo_rd_en_d;
    logic             busy_q,       busy_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             tick_next;
    logic             baud_clear;
    logic             can_start;

    // Any state change restarts the bit timer, so the new state begins at
    // cycle 0 of a full bit time.
    assign baud_clear = (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear     (baud_clear),
        .tick      (tick),
        .tick_next (tick_next)
    );

    // fifo_empty is used only where this is evaluated: in IDLE and in the
    // final stop cycle.
    assign can_start = enable && !fifo.fifo_empty;

    // FSM next state, shifter, bit counter and parity capture
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Strobe cycle; the word arrives in the next cycle.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = fifo.fifo_rd_data;
                parity_d  = calc_parity(PARITY_MAX_W'(fifo.fifo_rd_data), PARITY_ODD != 0);
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = can_start ? ST_FETCH : ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the next state so they line up with it
    always_comb begin
        tx_d         = IDLE_LEVEL;
        fifo_rd_en_d = (state_d == ST_FETCH);
        busy_d       = (state_d != ST_IDLE);
        // tick_next in the last stop bit means that the next cycle is the
        // final cycle of the frame.
        frame_done_d = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && tick_next;
        case (state_d)
            ST_START:  tx_d = START_LEVEL;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = IDLE_LEVEL;
        endcase
    end

    // State and output registers; a reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            tx_q         <= IDLE_LEVEL;
            fifo_rd_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx              = tx_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign fifo.fifo_rd_en = fifo_rd_en_q;
    assign dbg_state       = tx_state_t'(state_q);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. There are three instances with CLKS_PER_BIT=4 and
// WIDTH=8: instance 0 has no parity and one stop bit, instance 1 has even
// parity and two stop bits, and instance 2 has odd parity and two stop bits.
// Each instance has a behavioural FIFO and a frame monitor. The monitor
// decodes tx cycle by cycle and compares each frame with the next entry in
// that instance's expected queue.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int EW  = 10;   // {check_gap, parity, data[7:0]}

    logic clk;
    logic rst;
    logic enable;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // Shared comparison: counts every check and reports each failure.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock: 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PEN   = (g == 0) ? 0 : 1;
        localparam int PODD  = (g == 2) ? 1 : 0;
        localparam int SB    = (g == 0) ? 1 : 2;
        localparam int NSLOT = 1 + 8 + PEN + SB;

        fifo_uart_tx_if #(.WIDTH(8)) bus ();
        logic          tx;
        logic          busy;
        logic          frame_done;
        tx_state_t     dbg_state;

        logic [7:0]    fifo_q[$];
        logic [EW-1:0] exp_q[$];
        int            rd_cnt   = 0;
        int            done_cnt = 0;

        fifo_uart_tx #(
            .WIDTH        (8),
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PEN),
            .PARITY_ODD   (PODD),
            .STOP_BITS    (SB)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .fifo       (bus),
            .tx         (tx),
            .busy       (busy),
            .frame_done (frame_done),
            .dbg_state  (dbg_state)
        );

        // FIFO model: data is valid the cycle after a strobe. In every other
        // cycle it holds a filler value, so a late sample shows up.
        always @(posedge clk) begin
            if (bus.fifo_rd_en === 1'b1) begin
                rd_cnt <= rd_cnt + 1;
                if (fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
                else                   bus.fifo_rd_data <= 8'hEE;
            end else begin
                bus.fifo_rd_data <= 8'hEE;
            end
            bus.fifo_empty <= (fifo_q.size() == 0);
            if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        end

        // Frame monitor: decodes a whole frame from its first start cycle
        initial begin : monitor
            logic [EW-1:0] exp_v;
            logic [7:0]    data_v;
            logic          par_v;
            logic          bit_v;
            logic          shape_ok;
            logic          aborted;
            logic          have;
            int            gap;
            gap = 0;
            forever begin
                @(negedge clk);
                if (rst === 1'b1) begin
                    gap = 0;
                end else if (tx === 1'b1) begin
                    gap++;
                end else if (tx === 1'b0) begin
                    shape_ok = 1'b1;
                    aborted  = 1'b0;
                    data_v   = '0;
                    par_v    = 1'b0;
                    bit_v    = 1'b0;
                    for (int s = 0; s < NSLOT; s++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (s != 0 || c != 0) @(negedge clk);
                            if (rst === 1'b1) aborted = 1'b1;
                            if (c == 0) bit_v = tx;
                            else if (tx !== bit_v) shape_ok = 1'b0;
                            if (busy !== 1'b1) shape_ok = 1'b0;
                            if (frame_done !== ((s == NSLOT - 1) && (c == CPB - 1))) shape_ok = 1'b0;
                        end
                        if (s == 0) begin
                            if (bit_v !== 1'b0) shape_ok = 1'b0;
                        end else if (s <= 8) begin
                            data_v[s-1] = bit_v;
                        end else if (PEN != 0 && s == 9) begin
                            par_v = bit_v;
                        end else begin
                            if (bit_v !== 1'b1) shape_ok = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        have = (exp_q.size() != 0);
                        check($sformatf("dut%0d_frame_expected", g), 32'(have), 32'd1);
                        if (have) begin
                            exp_v = exp_q.pop_front();
                            check($sformatf("dut%0d_frame_data", g), 32'({par_v, data_v}), 32'(exp_v[8:0]));
                            check($sformatf("dut%0d_frame_shape", g), 32'(shape_ok), 32'd1);
                            if (exp_v[9]) check($sformatf("dut%0d_b2b_gap", g), 32'(gap), 32'd2);
                        end
                    end
                    gap = 0;
                end
            end
        end
    end

    int   rd0;
    int   done0;
    logic quiet;

    // Directed sequence
    initial begin
        rst    = 1'b1;
        enable = 1'b1;

        // 1. Reset, then idle with an empty FIFO
        repeat (3) @(negedge clk);
        check("reset_tx",         32'(g_dut[0].tx), 32'd1);
        check("reset_busy",       32'(g_dut[0].busy), 32'd0);
        check("reset_rd_en",      32'(g_dut[0].bus.fifo_rd_en), 32'd0);
        check("reset_frame_done", 32'(g_dut[0].frame_done), 32'd0);
        check("reset_state",      32'(g_dut[0].dbg_state), 32'(TX_IDLE));
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (g_dut[0].tx !== 1'b1 || g_dut[0].busy !== 1'b0 || g_dut[0].bus.fifo_rd_en !== 1'b0)
                quiet = 1'b0;
        end
        check("idle_quiet", 32'(quiet), 32'd1);

        // 2. Single byte 0xA5, with the start latency checked cycle by cycle
        rd0   = g_dut[0].rd_cnt;
        done0 = g_dut[0].done_cnt;
        g_dut[0].fifo_q.push_back(8'hA5);
        g_dut[0].exp_q.push_back({1'b0, 1'b0, 8'hA5});
        @(negedge clk);   // empty falls at this edge; still IDLE
        check("lat_idle_tx",    32'(g_dut[0].tx), 32'd1);
        check("lat_idle_rd_en", 32'(g_dut[0].bus.fifo_rd_en), 32'd0);
        @(negedge clk);   // FETCH
        check("fetch_rd_en",    32'(g_dut[0].bus.fifo_rd_en), 32'd1);
        check("fetch_busy",     32'(g_dut[0].busy), 32'd1);
        check("fetch_state",    32'(g_dut[0].dbg_state), 32'(TX_FETCH));
        @(negedge clk);   // LOAD
        check("load_tx_high",   32'(g_dut[0].tx), 32'd1);
        check("load_rd_en_low", 32'(g_dut[0].bus.fifo_rd_en), 32'd0);
        @(negedge clk);   // START
        check("start_latency",  32'(g_dut[0].tx), 32'd0);
        repeat (50) @(negedge clk);
        check("single_rd_pulses", 32'(g_dut[0].rd_cnt - rd0), 32'd1);
        check("single_done",      32'(g_dut[0].done_cnt - done0), 32'd1);
        check("single_idle",      32'(g_dut[0].dbg_state), 32'(TX_IDLE));
        check("single_busy_low",  32'(g_dut[0].busy), 32'd0);

        // 3. Back-to-back frames 0x00, 0xFF, 0x3C
        rd0   = g_dut[0].rd_cnt;
        done0 = g_dut[0].done_cnt;
        g_dut[0].fifo_q.push_back(8'h00);
        g_dut[0].fifo_q.push_back(8'hFF);
        g_dut[0].fifo_q.push_back(8'h3C);
        g_dut[0].exp_q.push_back({1'b0, 1'b0, 8'h00});
        g_dut[0].exp_q.push_back({1'b1, 1'b0, 8'hFF});
        g_dut[0].exp_q.push_back({1'b1, 1'b0, 8'h3C});
        repeat (150) @(negedge clk);
        check("b2b_rd_pulses", 32'(g_dut[0].rd_cnt - rd0), 32'd3);
        check("b2b_done",      32'(g_dut[0].done_cnt - done0), 32'd3);
        check("b2b_idle",      32'(g_dut[0].dbg_state), 32'(TX_IDLE));

        // 4. Parity with two stop bits: 0x07 has three ones
        g_dut[1].fifo_q.push_back(8'h07);
        g_dut[1].exp_q.push_back({1'b0, 1'b1, 8'h07});   // even parity -> 1
        g_dut[2].fifo_q.push_back(8'h07);
        g_dut[2].exp_q.push_back({1'b0, 1'b0, 8'h07});   // odd parity  -> 0
        repeat (70) @(negedge clk);
        check("even_par_done", 32'(g_dut[1].done_cnt), 32'd1);
        check("odd_par_done",  32'(g_dut[2].done_cnt), 32'd1);
        check("even_par_rd",   32'(g_dut[1].rd_cnt), 32'd1);
        check("odd_par_rd",    32'(g_dut[2].rd_cnt), 32'd1);

        // 5. Enable drops during the DATA bits of 0x55, with 0x99 queued
        rd0   = g_dut[0].rd_cnt;
        done0 = g_dut[0].done_cnt;
        g_dut[0].fifo_q.push_back(8'h55);
        g_dut[0].fifo_q.push_back(8'h99);
        g_dut[0].exp_q.push_back({1'b0, 1'b0, 8'h55});
        repeat (12) @(negedge clk);
        check("gate_in_data", 32'(g_dut[0].dbg_state), 32'(TX_DATA));
        enable = 1'b0;
        repeat (60) @(negedge clk);
        check("gate_rd_pulses", 32'(g_dut[0].rd_cnt - rd0), 32'd1);
        check("gate_done",      32'(g_dut[0].done_cnt - done0), 32'd1);
        check("gate_idle",      32'(g_dut[0].dbg_state), 32'(TX_IDLE));
        g_dut[0].exp_q.push_back({1'b0, 1'b0, 8'h99});
        enable = 1'b1;
        repeat (60) @(negedge clk);
        check("gate_resume_rd",   32'(g_dut[0].rd_cnt - rd0), 32'd2);
        check("gate_resume_done", 32'(g_dut[0].done_cnt - done0), 32'd2);

        // 6. Reset during data bit 3 of 0x81; the byte is dropped
        rd0   = g_dut[0].rd_cnt;
        done0 = g_dut[0].done_cnt;
        g_dut[0].fifo_q.push_back(8'h81);
        repeat (21) @(negedge clk);
        check("abort_bit3_low", 32'(g_dut[0].tx), 32'd0);
        rst   = 1'b1;
        quiet = 1'b1;
        @(negedge clk);
        check("abort_tx_high",  32'(g_dut[0].tx), 32'd1);
        check("abort_busy_low", 32'(g_dut[0].busy), 32'd0);
        check("abort_state",    32'(g_dut[0].dbg_state), 32'(TX_IDLE));
        repeat (3) begin
            if (g_dut[0].bus.fifo_rd_en !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("abort_no_rd_in_rst", 32'(quiet), 32'd1);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_rd_pulses", 32'(g_dut[0].rd_cnt - rd0), 32'd1);
        check("abort_no_done",   32'(g_dut[0].done_cnt - done0), 32'd0);
        check("abort_idle_tx",   32'(g_dut[0].tx), 32'd1);

        // Every expected frame must have been seen
        check("dut0_exp_drained", 32'(g_dut[0].exp_q.size()), 32'd0);
        check("dut1_exp_drained", 32'(g_dut[1].exp_q.size()), 32'd0);
        check("dut2_exp_drained", 32'(g_dut[2].exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
